// File: rtl/l2_mem_init_ctrl_pkg.sv
// Shared helpers for the L2 memory initialization controller.
package l2_mem_init_ctrl_pkg;

  // Number of low byte-address bits that select a byte within one data word.
  function automatic int unsigned word_offset_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/l2_mem_init_ctrl_if.sv
// Upstream memory port between axi2mem and the L2 init controller.
interface l2_mem_init_ctrl_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  logic                   req;
  logic                   gnt;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] strb;
  logic                   we;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;

  // Requester side (the AXI-to-memory converter).
  modport master (
    output req, addr, wdata, strb, we,
    input  gnt, rvalid, rdata
  );

  // Responder side (the init controller).
  modport slave (
    input  req, addr, wdata, strb, we,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/l2_mem_init_ctrl.sv
// L2 SRAM initialization controller: sweeps InitValue into every word after
// reset or clear, then passes upstream requests straight through to the SRAM.
module l2_mem_init_ctrl
  import l2_mem_init_ctrl_pkg::*;
#(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          NumWords  = 1024,
  parameter logic [DataWidth-1:0] InitValue = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  output logic                        init_done_o,
  l2_mem_init_ctrl_if.slave           mem,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [$clog2(NumWords)-1:0] sram_addr_o,
  output logic [DataWidth-1:0]        sram_wdata_o,
  output logic [DataWidth/8-1:0]      sram_be_o,
  input  logic [DataWidth-1:0]        sram_rdata_i
);

  localparam int unsigned CntW = $clog2(NumWords);
  localparam int unsigned OffW = word_offset_bits(DataWidth);

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rvalid_q;
  logic              gnt;

  // Only the word-index bits reach the SRAM; the rest alias by design.
  logic [AddrWidth-1:0] unused_addr;
  assign unused_addr = mem.addr;

  // Next state, counter and SRAM/grant muxing; INIT owns the SRAM port.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt          = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    unique case (state_q)
      StInit: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = cnt_q;
        sram_wdata_o = InitValue;
        sram_be_o    = '1;
        if (clear_i) begin
          // Restart the sweep; the word written this cycle still lands.
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(NumWords - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
      end
      StRun: begin
        gnt          = 1'b1;
        sram_req_o   = mem.req;
        sram_we_o    = mem.we;
        sram_addr_o  = mem.addr[OffW +: CntW];
        sram_wdata_o = mem.wdata;
        sram_be_o    = mem.strb;
        // The request in the clear cycle is still granted and answered.
        if (clear_i) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // State, sweep counter and fixed-latency response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= mem.req & gnt;
    end
  end

  assign mem.gnt     = gnt;
  assign mem.rvalid  = rvalid_q;
  assign mem.rdata   = sram_rdata_i;
  assign init_done_o = (state_q == StRun);

endmodule

// File: tb/tb_l2_mem_init_ctrl.sv
// Scoreboard bench for l2_mem_init_ctrl with a behavioural 16-word SRAM.
module tb_l2_mem_init_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned NW = 16;
  localparam logic [63:0] IV = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] WD = 64'h1122_3344_5566_7788;
  localparam logic [63:0] MERGED = 64'hA5A5_A5A5_5566_7788;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        clear = 1'b0;
  logic        init_done;
  logic        sram_req, sram_we;
  logic [3:0]  sram_addr;
  logic [63:0] sram_wdata, sram_rdata;
  logic [7:0]  sram_be;

  l2_mem_init_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) mem_if ();

  l2_mem_init_ctrl #(
    .AddrWidth(AW), .DataWidth(DW), .NumWords(NW), .InitValue(IV)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .init_done_o(init_done),
    .mem(mem_if.slave),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-enabled writes, one-cycle read latency.
  logic [63:0] sram [NW];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_be[b]) sram[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram[sram_addr];
      end
    end
  end

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic chk; logic [63:0] data; } exp_t;
  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [63:0] ref_mem [NW];
  logic        exp_rv = 1'b0;
  logic [3:0]  mon_w;

  // Scoreboard: every granted request owes exactly one response next cycle.
  always @(negedge clk) begin
    if (!rst_ni) begin
      sb_q.delete();
      exp_rv = 1'b0;
    end else begin
      tests++;
      if (mem_if.rvalid !== exp_rv) begin
        fails++;
        $display("FAIL sb_rvalid t=%0t: got %b want %b", $time, mem_if.rvalid, exp_rv);
      end
      if (exp_rv && sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        if (sb_e.chk) begin
          tests++;
          if (mem_if.rdata !== sb_e.data) begin
            fails++;
            $display("FAIL sb_rdata t=%0t: got %h want %h", $time, mem_if.rdata, sb_e.data);
          end
        end
      end
      exp_rv = (mem_if.req === 1'b1) && (mem_if.gnt === 1'b1);
      if (exp_rv) begin
        mon_w = mem_if.addr[3 +: 4];
        if (mem_if.we) begin
          for (int b = 0; b < 8; b++)
            if (mem_if.strb[b]) ref_mem[mon_w][b*8 +: 8] = mem_if.wdata[b*8 +: 8];
          sb_q.push_back('{chk: 1'b0, data: 64'h0});
        end else begin
          sb_q.push_back('{chk: 1'b1, data: ref_mem[mon_w]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_if.req   = 1'b0;
    mem_if.we    = 1'b0;
    mem_if.addr  = '0;
    mem_if.wdata = '0;
    mem_if.strb  = '0;
    clear        = 1'b0;
  endtask

  // Called at the drive point of the first INIT cycle; returns at the
  // negedge of the first RUN cycle.
  task automatic run_sweep(input string tag);
    for (int c = 0; c <= int'(NW); c++) begin
      @(negedge clk);
      tests++;
      if (c < int'(NW)) begin
        if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 4'(c) ||
            sram_be !== 8'hFF || sram_wdata !== IV || mem_if.gnt !== 1'b0 ||
            init_done !== 1'b0) begin
          fails++;
          $display("FAIL %s_sweep c=%0d: req=%b we=%b addr=%0d be=%h wdata=%h gnt=%b done=%b (want 1 1 %0d ff %h 0 0)",
                   tag, c, sram_req, sram_we, sram_addr, sram_be, sram_wdata, mem_if.gnt, init_done, c, IV);
        end
        step();
      end else if (init_done !== 1'b1 || mem_if.gnt !== 1'b1) begin
        fails++;
        $display("FAIL %s_done c=%0d: done=%b gnt=%b want 1 1", tag, c, init_done, mem_if.gnt);
      end
    end
    for (int i = 0; i < int'(NW); i++) ref_mem[i] = IV;
  endtask

  task automatic test_reset();
    idle();
    // Read of byte 0x48 (word 9) held from the first INIT cycle.
    mem_if.req  = 1'b1;
    mem_if.addr = 32'h48;
    #1 rst_ni = 1'b0;
    #1;
    tests++;
    if (init_done !== 1'b0 || mem_if.gnt !== 1'b0 || mem_if.rvalid !== 1'b0 ||
        sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 4'd0) begin
      fails++;
      $display("FAIL reset_vals: done=%b gnt=%b rv=%b req=%b we=%b addr=%0d want 0 0 0 1 1 0",
               init_done, mem_if.gnt, mem_if.rvalid, sram_req, sram_we, sram_addr);
    end
    step();
    rst_ni = 1'b1;
    run_sweep("reset");
    step();
    mem_if.req = 1'b0;
    #1;
    tests++;
    if (mem_if.rvalid !== 1'b1 || mem_if.rdata !== IV) begin
      fails++;
      $display("FAIL held_read: rv=%b rdata=%h want 1 %h", mem_if.rvalid, mem_if.rdata, IV);
    end
    step();
    #1;
    tests++;
    if (mem_if.rvalid !== 1'b0) begin
      fails++;
      $display("FAIL held_once: rv=%b want 0", mem_if.rvalid);
    end
  endtask

  task automatic test_back_to_back();
    step();
    mem_if.req = 1'b1; mem_if.we = 1'b1; mem_if.addr = 32'd24;
    mem_if.wdata = WD; mem_if.strb = 8'h0F;
    @(negedge clk);
    tests++;
    if (mem_if.gnt !== 1'b1 || sram_req !== 1'b1 || sram_we !== 1'b1 ||
        sram_addr !== 4'd3 || sram_be !== 8'h0F || sram_wdata !== WD) begin
      fails++;
      $display("FAIL b2b_wr_pass: gnt=%b req=%b we=%b addr=%0d be=%h wd=%h want 1 1 1 3 0f %h",
               mem_if.gnt, sram_req, sram_we, sram_addr, sram_be, sram_wdata, WD);
    end
    step();
    mem_if.we = 1'b0; mem_if.wdata = '0; mem_if.strb = '0;
    @(negedge clk);
    tests++;
    if (mem_if.rvalid !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 4'd3) begin
      fails++;
      $display("FAIL b2b_rd_issue: rv=%b we=%b addr=%0d want 1 0 3", mem_if.rvalid, sram_we, sram_addr);
    end
    step();
    mem_if.addr = 32'hC8;  // aliases word 9
    @(negedge clk);
    tests++;
    if (mem_if.rvalid !== 1'b1 || mem_if.rdata !== MERGED || sram_addr !== 4'd9) begin
      fails++;
      $display("FAIL b2b_merge: rv=%b rdata=%h addr=%0d want 1 %h 9", mem_if.rvalid, mem_if.rdata, sram_addr, MERGED);
    end
    step();
    mem_if.req = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_if.rvalid !== 1'b1 || mem_if.rdata !== IV) begin
      fails++;
      $display("FAIL b2b_alias: rv=%b rdata=%h want 1 %h", mem_if.rvalid, mem_if.rdata, IV);
    end
  endtask

  task automatic test_clear_run();
    step();
    mem_if.req = 1'b1; mem_if.we = 1'b0; mem_if.addr = 32'd24; clear = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_if.gnt !== 1'b1 || init_done !== 1'b1 || sram_req !== 1'b1 ||
        sram_we !== 1'b0 || sram_addr !== 4'd3) begin
      fails++;
      $display("FAIL clr_run_issue: gnt=%b done=%b req=%b we=%b addr=%0d want 1 1 1 0 3",
               mem_if.gnt, init_done, sram_req, sram_we, sram_addr);
    end
    step();
    idle();
    #1;
    tests++;
    if (init_done !== 1'b0 || mem_if.rvalid !== 1'b1 || mem_if.rdata !== MERGED || mem_if.gnt !== 1'b0) begin
      fails++;
      $display("FAIL clr_run_resp: done=%b rv=%b rdata=%h gnt=%b want 0 1 %h 0",
               init_done, mem_if.rvalid, mem_if.rdata, mem_if.gnt, MERGED);
    end
    run_sweep("clr_run");
    step();
    mem_if.req = 1'b1; mem_if.addr = 32'd24;
    step();
    idle();
    #1;
    tests++;
    if (mem_if.rvalid !== 1'b1 || mem_if.rdata !== IV) begin
      fails++;
      $display("FAIL clr_run_reinit: rv=%b rdata=%h want 1 %h", mem_if.rvalid, mem_if.rdata, IV);
    end
  endtask

  task automatic test_clear_init();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      step();
    end
    clear = 1'b1;
    @(negedge clk);
    tests++;
    if (sram_addr !== 4'd9 || sram_we !== 1'b1 || init_done !== 1'b0) begin
      fails++;
      $display("FAIL clr_init_pulse: addr=%0d we=%b done=%b want 9 1 0", sram_addr, sram_we, init_done);
    end
    step();
    clear = 1'b0;
    run_sweep("clr_init");
  endtask

  task automatic test_async_reset();
    // Mid-RUN: a granted read's response must be killed by reset.
    step();
    mem_if.req = 1'b1; mem_if.addr = 32'd16;
    step();
    idle();
    tests++;
    if (mem_if.rvalid !== 1'b1) begin
      fails++;
      $display("FAIL rst_run_pre: rv=%b want 1", mem_if.rvalid);
    end
    #1 rst_ni = 1'b0;
    #1;
    tests++;
    if (mem_if.rvalid !== 1'b0 || mem_if.gnt !== 1'b0 || init_done !== 1'b0 ||
        sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 4'd0) begin
      fails++;
      $display("FAIL rst_run_async: rv=%b gnt=%b done=%b req=%b we=%b addr=%0d want 0 0 0 1 1 0",
               mem_if.rvalid, mem_if.gnt, init_done, sram_req, sram_we, sram_addr);
    end
    @(posedge clk);
    step();
    rst_ni = 1'b1;
    run_sweep("rst_run");
    // Mid-INIT: reset at cnt=5 restarts the full sweep.
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      step();
    end
    tests++;
    if (sram_addr !== 4'd5) begin
      fails++;
      $display("FAIL rst_init_pre: addr=%0d want 5", sram_addr);
    end
    #1 rst_ni = 1'b0;
    #1;
    tests++;
    if (sram_addr !== 4'd0 || mem_if.gnt !== 1'b0 || init_done !== 1'b0 || mem_if.rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_init_async: addr=%0d gnt=%b done=%b rv=%b want 0 0 0 0",
               sram_addr, mem_if.gnt, init_done, mem_if.rvalid);
    end
    @(posedge clk);
    step();
    rst_ni = 1'b1;
    run_sweep("rst_init");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_clear_run();
    test_clear_init();
    test_async_reset();
    step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
